// File: rtl/ob_pkg.sv
// rtl/ob_pkg.sv - shared types for the ob table counting blocks
// Purpose: CSA compression selector and the accumulator sequencer state encoding.
package ob_pkg;

  typedef enum logic [0:0] {
    CSA_3_2,
    CSA_7_2
  } csa_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    CPA,
    DONE
  } ob_table_cnt_seq_state_t;

endpackage

// File: rtl/ob_table_cnt_csa.sv
// rtl/ob_table_cnt_csa.sv - combinational carry-save reduction of N words to a sum/carry pair
// Purpose: reduces N W-bit words so that s_w + c_w equals their sum modulo 2^W.
// Ports:
//   x    in  [N][W]  words to reduce
//   s_w  out [W]     save (sum) vector
//   c_w  out [W]     carry vector, already shifted into weight position
module ob_table_cnt_csa
  import ob_pkg::*;
#(
  parameter int      W  = 32,
  parameter int      N  = 8,
  parameter csa_op_t OP = CSA_3_2
) (
  input  logic [N-1:0][W-1:0] x,
  output logic [W-1:0]        s_w,
  output logic [W-1:0]        c_w
);

  function automatic logic [W-1:0] fa_s(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    return a ^ b ^ c;
  endfunction

  // Majority shifted up one place; the carry out of bit W-1 is dropped (mod 2^W).
  function automatic logic [W-1:0] fa_c(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  always_comb begin
    logic [W-1:0] s, c, s1, c1;
    s  = x[0];
    c  = x[1];
    s1 = '0;
    c1 = '0;
    if (OP == CSA_3_2) begin
      // Linear chain of 3:2 compressors.
      for (int i = 2; i < N; i++) begin
        s1 = fa_s(s, c, x[i]);
        c1 = fa_c(s, c, x[i]);
        s  = s1;
        c  = c1;
      end
    end else begin
      // 4:2 steps: two new words meet the save vector first, the carry joins second.
      for (int i = 2; i < N; i += 2) begin
        int j;
        j = (i + 1 < N) ? i + 1 : N - 1;
        if (i + 1 < N) begin
          s1 = fa_s(x[i], x[j], s);
          c1 = fa_c(x[i], x[j], s);
          s  = fa_s(s1, c1, c);
          c  = fa_c(s1, c1, c);
        end else begin
          s1 = fa_s(s, c, x[i]);
          c1 = fa_c(s, c, x[i]);
          s  = s1;
          c  = c1;
        end
      end
    end
    s_w = s;
    c_w = c;
  end

endmodule

// File: rtl/ob_table_cnt_seq.sv
// rtl/ob_table_cnt_seq.sv - multi-beat carry-save accumulator with final carry-propagate add
// Purpose: sums a stream of masked W-bit lanes (N-2 per beat) and counts enabled lanes.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   clr                 synchronous abort of any accumulation (highest priority)
//   in_vld/in_rdy       input beat handshake; in_w lanes, in_msk lane enables, in_last
//   out_vld/out_rdy     result handshake; out_sum total, out_cnt saturating lane count
//   busy                accumulation in progress
module ob_table_cnt_seq
  import ob_pkg::*;
#(
  parameter int      W     = 32,
  parameter int      N     = 8,
  parameter csa_op_t OP    = CSA_3_2,
  parameter int      CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_vld,
  input  logic [N-3:0][W-1:0]   in_w,
  input  logic [N-3:0]          in_msk,
  input  logic                  in_last,
  output logic                  in_rdy,
  output logic                  out_vld,
  output logic [W-1:0]          out_sum,
  output logic [CNT_W-1:0]      out_cnt,
  input  logic                  out_rdy,
  output logic                  busy
);

  localparam int L = N - 2;

  ob_table_cnt_seq_state_t state_q, state_d;
  logic [W-1:0]        s_r, c_r;
  logic [N-1:0][W-1:0] csa_x;
  logic [W-1:0]        s_w, c_w;
  logic [CNT_W:0]      cnt_sum;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                accept;

  function automatic logic [CNT_W-1:0] popcount(input logic [L-1:0] m);
    logic [CNT_W-1:0] pc;
    pc = '0;
    for (int i = 0; i < L; i++) pc = pc + CNT_W'(m[i]);
    return pc;
  endfunction

  // Tree inputs: masked lanes, then the fed-back carry/save pair.
  always_comb begin
    csa_x = '0;
    for (int l = 0; l < L; l++) csa_x[l] = in_msk[l] ? in_w[l] : '0;
    csa_x[L]   = s_r;
    csa_x[L+1] = c_r;
  end

  ob_table_cnt_csa #(.W(W), .N(N), .OP(OP)) u_csa (
    .x   (csa_x),
    .s_w (s_w),
    .c_w (c_w)
  );

  assign accept  = in_vld & in_rdy;
  assign cnt_sum = {1'b0, out_cnt} + {1'b0, popcount(in_msk)};
  assign cnt_nxt = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) state_d = in_last ? CPA : ACC;
      end
      ACC: begin
        in_rdy = 1'b1;
        if (in_vld && in_last) state_d = CPA;
      end
      CPA: state_d = DONE;
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q <= IDLE;
      s_r     <= '0;
      c_r     <= '0;
      out_sum <= '0;
      out_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        s_r     <= s_w;
        c_r     <= c_w;
        out_cnt <= cnt_nxt;
      end
      if (state_q == CPA) out_sum <= s_r + c_r;
      if (state_q == DONE && out_rdy) begin
        s_r     <= '0;
        c_r     <= '0;
        out_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ob_table_cnt_seq.sv
// tb/tb_ob_table_cnt_seq.sv - directed table-driven bench for ob_table_cnt_seq
module tb_ob_table_cnt_seq;
  import ob_pkg::*;

  localparam logic [31:0] G = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clr, vld, last, ordy;
  logic [5:0][31:0] w;
  logic [5:0] msk;
  logic a_rdy, a_vld, a_busy, b_rdy, b_vld, b_busy;
  logic [31:0] a_sum, b_sum;
  logic [15:0] a_cnt, b_cnt;

  logic c_clr, c_vld, c_last, c_ordy, c_rdy, c_ovld, c_busy;
  logic [0:0][31:0] c_w;
  logic [0:0] c_msk;
  logic [31:0] c_sum;
  logic [15:0] c_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  ob_table_cnt_seq #(.W(32), .N(8), .OP(CSA_3_2), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(vld), .in_w(w), .in_msk(msk),
    .in_last(last), .in_rdy(a_rdy), .out_vld(a_vld), .out_sum(a_sum), .out_cnt(a_cnt),
    .out_rdy(ordy), .busy(a_busy));

  ob_table_cnt_seq #(.W(32), .N(8), .OP(CSA_7_2), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(vld), .in_w(w), .in_msk(msk),
    .in_last(last), .in_rdy(b_rdy), .out_vld(b_vld), .out_sum(b_sum), .out_cnt(b_cnt),
    .out_rdy(ordy), .busy(b_busy));

  ob_table_cnt_seq #(.W(32), .N(3), .OP(CSA_3_2), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .in_vld(c_vld), .in_w(c_w), .in_msk(c_msk),
    .in_last(c_last), .in_rdy(c_rdy), .out_vld(c_ovld), .out_sum(c_sum), .out_cnt(c_cnt),
    .out_rdy(c_ordy), .busy(c_busy));

  typedef struct {
    logic vld; logic last; logic [5:0] msk; logic [5:0][31:0] w; logic ordy; logic clr;
    logic e_rdy; logic e_vld; logic e_busy; logic [1:0] chk; logic [31:0] e_sum; logic [15:0] e_cnt;
  } row_t;

  row_t rows[$];

  function automatic logic [5:0][31:0] ln(input logic [31:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [5:0][31:0] all(input logic [31:0] v);
    return {v, v, v, v, v, v};
  endfunction

  // chk bit 1: compare out_sum, bit 0: compare out_cnt
  function automatic row_t mk(input logic v, input logic l, input logic [5:0] m,
                              input logic [5:0][31:0] ww, input logic o, input logic c,
                              input logic er, input logic ev, input logic eb,
                              input logic [1:0] ck, input logic [31:0] es, input logic [15:0] ec);
    row_t r;
    r.vld = v; r.last = l; r.msk = m; r.w = ww; r.ordy = o; r.clr = c;
    r.e_rdy = er; r.e_vld = ev; r.e_busy = eb; r.chk = ck; r.e_sum = es; r.e_cnt = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive8(input logic v, input logic l, input logic [5:0] m,
                        input logic [5:0][31:0] ww, input logic o, input logic c);
    @(negedge clk);
    vld = v; last = l; msk = m; w = ww; ordy = o; clr = c;
  endtask

  task automatic chk8(input string nm, input logic er, input logic ev,
                      input logic [31:0] es, input logic [15:0] ec);
    #1;
    chk({nm, " a_rdy"}, 32'(a_rdy), 32'(er));
    chk({nm, " a_vld"}, 32'(a_vld), 32'(ev));
    chk({nm, " a_sum"}, a_sum, es);
    chk({nm, " a_cnt"}, 32'(a_cnt), 32'(ec));
    chk({nm, " b_rdy"}, 32'(b_rdy), 32'(er));
    chk({nm, " b_vld"}, 32'(b_vld), 32'(ev));
    chk({nm, " b_sum"}, b_sum, es);
    chk({nm, " b_cnt"}, 32'(b_cnt), 32'(ec));
  endtask

  initial begin
    logic [5:0][31:0] z;
    z = '0;
    // single beat {1..6}
    rows.push_back(mk(0,0,6'h00,z,0,0, 1,0,0, 2'b11, 0, 0));
    rows.push_back(mk(1,1,6'h3F,ln(1,2,3,4,5,6),0,0, 1,0,0, 2'b11, 0, 0));
    rows.push_back(mk(0,0,6'h00,z,0,0, 0,0,1, 2'b01, 0, 6));
    rows.push_back(mk(0,0,6'h00,z,1,0, 0,1,1, 2'b11, 21, 6));
    // three back-to-back beats of 2^28
    rows.push_back(mk(1,0,6'h3F,all(32'h1000_0000),0,0, 1,0,0, 2'b01, 0, 0));
    rows.push_back(mk(1,0,6'h3F,all(32'h1000_0000),0,0, 1,0,1, 2'b01, 0, 6));
    rows.push_back(mk(1,1,6'h3F,all(32'h1000_0000),0,0, 1,0,1, 2'b01, 0, 12));
    rows.push_back(mk(0,0,6'h00,z,0,0, 0,0,1, 2'b01, 0, 18));
    rows.push_back(mk(0,0,6'h00,z,1,0, 0,1,1, 2'b11, 32'h2000_0000, 18));
    // sparse mask, empty last beat, stalled consumer, ignored beats while not ready
    rows.push_back(mk(1,0,6'b000101,ln(7,G,9,G,G,G),0,0, 1,0,0, 2'b01, 0, 0));
    rows.push_back(mk(1,1,6'h00,all(G),0,0, 1,0,1, 2'b01, 0, 2));
    rows.push_back(mk(1,1,6'h3F,all(G),0,0, 0,0,1, 2'b01, 0, 2));
    for (int k = 0; k < 5; k++) rows.push_back(mk(1,1,6'h3F,all(G),0,0, 0,1,1, 2'b11, 16, 2));
    rows.push_back(mk(0,0,6'h00,z,1,0, 0,1,1, 2'b11, 16, 2));
    rows.push_back(mk(1,1,6'h01,ln(10,G,G,G,G,G),0,0, 1,0,0, 2'b01, 0, 0));
    rows.push_back(mk(0,0,6'h00,z,0,0, 0,0,1, 2'b01, 0, 1));
    rows.push_back(mk(0,0,6'h00,z,1,0, 0,1,1, 2'b11, 10, 1));
    // clr in ACC (with an idle gap), discarded beat, then a fresh {1}
    rows.push_back(mk(1,0,6'h3F,all(5),0,0, 1,0,0, 2'b01, 0, 0));
    rows.push_back(mk(0,0,6'h00,z,0,0, 1,0,1, 2'b01, 0, 6));
    rows.push_back(mk(1,0,6'h3F,all(5),0,0, 1,0,1, 2'b01, 0, 6));
    rows.push_back(mk(1,1,6'h3F,all(G),0,1, 1,0,1, 2'b01, 0, 12));
    rows.push_back(mk(1,1,6'h01,ln(1,G,G,G,G,G),0,0, 1,0,0, 2'b11, 0, 0));
    rows.push_back(mk(0,0,6'h00,z,0,0, 0,0,1, 2'b01, 0, 1));
    rows.push_back(mk(0,0,6'h00,z,1,0, 0,1,1, 2'b11, 1, 1));
    // clr in DONE wins over the output handshake and zeroes the result
    rows.push_back(mk(1,1,6'h01,ln(3,G,G,G,G,G),0,0, 1,0,0, 2'b01, 0, 0));
    rows.push_back(mk(0,0,6'h00,z,0,0, 0,0,1, 2'b01, 0, 1));
    rows.push_back(mk(0,0,6'h00,z,1,1, 0,1,1, 2'b11, 3, 1));
    rows.push_back(mk(0,0,6'h00,z,0,0, 1,0,0, 2'b11, 0, 0));

    rst_n = 1'b0; clr = 0; vld = 0; last = 0; msk = '0; w = '0; ordy = 0;
    c_clr = 0; c_vld = 0; c_last = 0; c_msk = '0; c_w = '0; c_ordy = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      vld = rows[i].vld; last = rows[i].last; msk = rows[i].msk; w = rows[i].w;
      ordy = rows[i].ordy; clr = rows[i].clr;
      #1;
      chk($sformatf("r%0d a_rdy", i), 32'(a_rdy), 32'(rows[i].e_rdy));
      chk($sformatf("r%0d a_vld", i), 32'(a_vld), 32'(rows[i].e_vld));
      chk($sformatf("r%0d a_busy", i), 32'(a_busy), 32'(rows[i].e_busy));
      chk($sformatf("r%0d b_rdy", i), 32'(b_rdy), 32'(rows[i].e_rdy));
      chk($sformatf("r%0d b_vld", i), 32'(b_vld), 32'(rows[i].e_vld));
      chk($sformatf("r%0d b_busy", i), 32'(b_busy), 32'(rows[i].e_busy));
      if (rows[i].chk[1]) begin
        chk($sformatf("r%0d a_sum", i), a_sum, rows[i].e_sum);
        chk($sformatf("r%0d b_sum", i), b_sum, rows[i].e_sum);
      end
      if (rows[i].chk[0]) begin
        chk($sformatf("r%0d a_cnt", i), 32'(a_cnt), 32'(rows[i].e_cnt));
        chk($sformatf("r%0d b_cnt", i), 32'(b_cnt), 32'(rows[i].e_cnt));
      end
    end

    // reset mid-accumulation discards the partial sum
    drive8(1, 0, 6'h3F, all(4), 0, 0);
    drive8(1, 0, 6'h3F, all(4), 0, 0);
    drive8(0, 0, 6'h00, z, 0, 0);
    rst_n = 1'b0;
    drive8(0, 0, 6'h00, z, 0, 0);
    rst_n = 1'b1;
    chk8("rst_mid", 1, 0, 0, 0);
    drive8(1, 1, 6'h01, ln(2,G,G,G,G,G), 0, 0);
    drive8(0, 0, 6'h00, z, 0, 0);
    drive8(0, 0, 6'h00, z, 1, 0);
    chk8("rst_after", 0, 1, 2, 1);

    // lane counter saturation: 10923 full beats of ones = 65538 lanes
    for (int k = 0; k < 10923; k++) drive8(1, (k == 10922), 6'h3F, all(1), 0, 0);
    drive8(0, 0, 6'h00, z, 0, 0);
    drive8(0, 0, 6'h00, z, 1, 0);
    chk8("sat", 0, 1, 32'd65538, 16'hFFFF);
    drive8(0, 0, 6'h00, z, 0, 0);
    chk8("sat_idle", 1, 0, 32'd65538, 16'h0000);

    // one lane per beat: 20 beats of all-ones
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      c_vld = 1; c_last = (k == 19); c_msk = 1'b1; c_w[0] = 32'hFFFF_FFFF;
    end
    @(negedge clk);
    c_vld = 0; c_last = 0;
    #1;
    chk("n3 cpa_rdy", 32'(c_rdy), 32'd0);
    chk("n3 cpa_vld", 32'(c_ovld), 32'd0);
    @(negedge clk);
    c_ordy = 1;
    #1;
    chk("n3 vld", 32'(c_ovld), 32'd1);
    chk("n3 sum", c_sum, 32'hFFFF_FFEC);
    chk("n3 cnt", 32'(c_cnt), 32'd20);
    chk("n3 busy", 32'(c_busy), 32'd1);
    @(negedge clk);
    c_ordy = 0;
    #1;
    chk("n3 idle_rdy", 32'(c_rdy), 32'd1);
    chk("n3 idle_busy", 32'(c_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
